fsm_sequencer: RTL and testbench
================================

Name: fsm_sequencer

Overview:
Execution core that consumes the instruction memory outputs. It holds the current state address and drives it back to the memory as `addr`. On each step it evaluates the selected condition, registers the then/else action and computes the next state. It owns the programmable down-counters, loaded from the memory's constant field, and the slow-mode prescaler. The top level holds `run` low while the memory is being programmed.

Parameters:
STATE_COUNT, 8, number of states; addr width SW = $clog2(STATE_COUNT)
COND_WIDTH, 2, width of condition select field
ACTION_WIDTH, 1, width of action outputs
COUNTER_WIDTH, 16, width of each down-counter
COUNTER_COUNT, 2, number of down-counters
IN_WIDTH, 1, external condition inputs
SLOW_DIV, 1000, clock cycles per step in slow mode (>=1)

Ports:
clock  in  1  clock
rst_n  in  1  synchronous, active-low reset
run  in  1  1 = execute; 0 = hold in idle/reload
ext_in  in  IN_WIDTH  external conditions; already synchronous to clock
jump_target  in  SW  from instruction word
repeat_state  in  1  from instruction word
slow_mode  in  1  from instruction word
cond  in  COND_WIDTH  condition select from instruction word
then_action  in  ACTION_WIDTH  from instruction word
else_action  in  ACTION_WIDTH  from instruction word
const_data  in  COUNTER_WIDTH*COUNTER_COUNT  counter reload values; counter i = slice [i*COUNTER_WIDTH +: COUNTER_WIDTH]
addr  out  SW  current state (registered) to instruction memory
action  out  ACTION_WIDTH  registered action
step  out  1  registered pulse, high the cycle after each executed step
ctr_done  out  COUNTER_COUNT  bit i = (counter i == 0)

Behaviour:
- Reset (rst_n=0 at a clock edge): addr=0, action=0, step=0, all counters=0, prescaler=0. Reset dominates run.
- Idle (run=0, not in reset):
  - addr<=0, action<=0, step<=0, prescaler<=0.
  - Counter i <= const_data slice i every cycle, so newly programmed constants take effect.
- Condition vector cv, length 2^COND_WIDTH:
  - cv[0]=1 (always true).
  - cv[1..COUNTER_COUNT] = ctr_done[0..COUNTER_COUNT-1].
  - Next IN_WIDTH bits = ext_in[0..].
  - Remaining bits = 0; excess sources are dropped.
  - c = cv[cond]. Selection is combinational from the current word and registered ctr_done.
- Step enable te:
  - run=1 and slow_mode=0: te=1 every cycle.
  - run=1 and slow_mode=1: prescaler counts 0..SLOW_DIV-1 and wraps; te=1 only in the cycle where prescaler==SLOW_DIV-1.
  - Prescaler increments only while run=1 and slow_mode=1, and clears to 0 whenever slow_mode=0.
- On a cycle with te=1:
  - If c=1: addr<=jump_target, action<=then_action.
  - If c=0 and repeat_state=1: addr unchanged, action<=else_action.
  - If c=0 and repeat_state=0: addr<=addr+1 modulo STATE_COUNT (STATE_COUNT-1 wraps to 0), action<=else_action.
  - step<=1.
- On a cycle with te=0 and run=1: addr, action and counters hold; step<=0.
- Counters, on te=1:
  - If the step is a "stay" (c=0 and repeat_state=1): each nonzero counter decrements by 1; counters at 0 stay at 0 (saturating, no wrap).
  - Otherwise, including a taken jump to the same address: all counters reload from const_data.
- Latency: addr, action, step and counters update on the clock edge that ends the te cycle. The new word and new ctr_done are used from the next te.
- run falling mid-operation: the next edge applies the idle behaviour; no pending step completes. run rising: the first cycle with run=1 is eligible for te, starting from state 0.
- A constant of 0 gives ctr_done=1 immediately after reload.

Test Plan:
- Reset with run=1, slow_mode=0, cond=0 -> addr=0, action=0, step=0, ctr_done=all 1 during reset; first post-reset cycle steps to jump_target.
- run=1, fast mode, every word has cond=0, jump_target=5, then_action=1 -> addr=5 and action=1 one cycle after run rises; step high every cycle.
- Word with cond=1 (ctr0_done), repeat_state=1, const0=3, else_action=0 -> stays 3 steps (counter 3→2→1→0), jumps on the 4th step; action=0 then then_action.
- cond selecting an always-0 (padding) bit, repeat_state=0, from addr=7 (STATE_COUNT=8) -> addr wraps to 0; counters reloaded.
- slow_mode=1, SLOW_DIV=4 -> step pulses every 4 cycles; addr changes only on those edges; toggling slow_mode to 0 resets prescaler.
- run dropped mid-count (ctr0=2) -> next cycle addr=0, action=0, ctr0=const0; rst_n low while run=1 -> all outputs 0 next edge.

Source files
------------

// File: rtl/fsm_sequencer_if.sv
// Instruction-memory bus between the sequencer and its program store.
// The sequencer drives the current state address; the store answers with the
// instruction word for that address in the same cycle.
interface fsm_sequencer_if #(
    parameter int STATE_COUNT   = 8,
    parameter int COND_WIDTH    = 2,
    parameter int ACTION_WIDTH  = 1,
    parameter int COUNTER_WIDTH = 16,
    parameter int COUNTER_COUNT = 2
);
    localparam int SW = (STATE_COUNT > 1) ? $clog2(STATE_COUNT) : 1;

    // Handshake: there is no valid/ready pair. The word is treated as valid
    // every cycle for the address currently on addr, and the sequencer never
    // applies backpressure; the store must answer combinationally.
    logic [SW-1:0]                          addr;
    logic [SW-1:0]                          jump_target;
    logic                                   repeat_state;
    logic                                   slow_mode;
    logic [COND_WIDTH-1:0]                  cond;
    logic [ACTION_WIDTH-1:0]                then_action;
    logic [ACTION_WIDTH-1:0]                else_action;
    logic [COUNTER_WIDTH*COUNTER_COUNT-1:0] const_data;

    // Instruction store side.
    modport master (
        input  addr,
        output jump_target, repeat_state, slow_mode, cond,
        output then_action, else_action, const_data
    );

    // Sequencer side.
    modport slave (
        output addr,
        input  jump_target, repeat_state, slow_mode, cond,
        input  then_action, else_action, const_data
    );
endinterface

// File: rtl/fsm_sequencer.sv
// Programmable state sequencer core: walks the instruction store, evaluates
// a selected condition each step, registers the then/else action, and owns
// the reloadable down-counters plus the slow-mode step prescaler.
module fsm_sequencer #(
    parameter int STATE_COUNT   = 8,
    parameter int COND_WIDTH    = 2,
    parameter int ACTION_WIDTH  = 1,
    parameter int COUNTER_WIDTH = 16,
    parameter int COUNTER_COUNT = 2,
    parameter int IN_WIDTH      = 1,
    parameter int SLOW_DIV      = 1000
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     run,
    input  logic [IN_WIDTH-1:0]      ext_in,
    fsm_sequencer_if.slave           imem,
    output logic [ACTION_WIDTH-1:0]  action,
    output logic                     step,
    output logic [COUNTER_COUNT-1:0] ctr_done
);
    localparam int SW     = (STATE_COUNT > 1) ? $clog2(STATE_COUNT) : 1;
    localparam int CV_LEN = 1 << COND_WIDTH;
    localparam int SRC_W  = 1 + COUNTER_COUNT + IN_WIDTH;
    localparam int PW     = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;

    localparam logic [SW-1:0] LAST_ADDR  = SW'(STATE_COUNT - 1);
    localparam logic [PW-1:0] LAST_PRESC = PW'(SLOW_DIV - 1);

    // What the current cycle does to the sequencer state.
    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,  // no step this cycle (idle or prescaler wait)
        STEP_JUMP    = 2'd1,  // condition true: go to jump_target
        STEP_STAY    = 2'd2,  // condition false, repeat: hold addr, count down
        STEP_ADVANCE = 2'd3   // condition false, no repeat: addr + 1
    } step_kind_e;

    logic [SW-1:0]                              addr_q, addr_d;
    logic [ACTION_WIDTH-1:0]                    action_q, action_d;
    logic                                       step_q, step_d;
    logic [PW-1:0]                              presc_q, presc_d;
    logic [COUNTER_COUNT-1:0][COUNTER_WIDTH-1:0] ctr_q, ctr_d;

    logic [CV_LEN+SRC_W-1:0] cv_src;
    logic [CV_LEN-1:0]       cv;
    logic                    cond_hit;
    logic                    te;
    step_kind_e              step_kind;

    // Counter-done flags come straight from the registered counters.
    always_comb begin
        for (int i = 0; i < COUNTER_COUNT; i++) begin
            ctr_done[i] = (ctr_q[i] == '0);
        end
    end

    // Condition vector: bit 0 always true, then counter-done flags, then
    // external inputs; zero-padded on top and truncated to the select range.
    always_comb begin
        cv_src   = {{CV_LEN{1'b0}}, ext_in, ctr_done, 1'b1};
        cv       = cv_src[CV_LEN-1:0];
        cond_hit = cv[imem.cond];
    end

    // Step enable and classification of the step.
    always_comb begin
        te        = run && (!imem.slow_mode || (presc_q == LAST_PRESC));
        step_kind = STEP_NONE;
        if (te) begin
            if (cond_hit) begin
                step_kind = STEP_JUMP;
            end else if (imem.repeat_state) begin
                step_kind = STEP_STAY;
            end else begin
                step_kind = STEP_ADVANCE;
            end
        end
    end

    // Next-state logic for address, action, step pulse, prescaler, counters.
    always_comb begin
        addr_d   = addr_q;
        action_d = action_q;
        step_d   = 1'b0;
        presc_d  = presc_q;
        ctr_d    = ctr_q;

        if (!run) begin
            // Idle: park at state 0 and keep counters tracking the constants.
            addr_d   = '0;
            action_d = '0;
            presc_d  = '0;
            for (int i = 0; i < COUNTER_COUNT; i++) begin
                ctr_d[i] = imem.const_data[i*COUNTER_WIDTH +: COUNTER_WIDTH];
            end
        end else begin
            if (!imem.slow_mode || (presc_q == LAST_PRESC)) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + PW'(1);
            end

            step_d = te;

            case (step_kind)
                STEP_JUMP: begin
                    addr_d   = imem.jump_target;
                    action_d = imem.then_action;
                end
                STEP_STAY: begin
                    action_d = imem.else_action;
                end
                STEP_ADVANCE: begin
                    addr_d   = (addr_q == LAST_ADDR) ? '0 : addr_q + SW'(1);
                    action_d = imem.else_action;
                end
                default: begin
                end
            endcase

            // A stay counts down (saturating); any other step reloads.
            if (step_kind == STEP_STAY) begin
                for (int i = 0; i < COUNTER_COUNT; i++) begin
                    if (ctr_q[i] != '0) begin
                        ctr_d[i] = ctr_q[i] - COUNTER_WIDTH'(1);
                    end
                end
            end else if (step_kind != STEP_NONE) begin
                for (int i = 0; i < COUNTER_COUNT; i++) begin
                    ctr_d[i] = imem.const_data[i*COUNTER_WIDTH +: COUNTER_WIDTH];
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            addr_q   <= '0;
            action_q <= '0;
            step_q   <= 1'b0;
            presc_q  <= '0;
            ctr_q    <= '0;
        end else begin
            addr_q   <= addr_d;
            action_q <= action_d;
            step_q   <= step_d;
            presc_q  <= presc_d;
            ctr_q    <= ctr_d;
        end
    end

    assign imem.addr = addr_q;
    assign action    = action_q;
    assign step      = step_q;
endmodule

// File: tb/tb_fsm_sequencer.sv
// Directed bench for fsm_sequencer: the bench plays the instruction store and
// sets each word by hand, checking registered outputs after every edge.
module tb_fsm_sequencer;
    localparam int STATE_COUNT   = 8;
    localparam int COND_WIDTH    = 2;
    localparam int ACTION_WIDTH  = 1;
    localparam int COUNTER_WIDTH = 16;
    localparam int COUNTER_COUNT = 2;
    localparam int IN_WIDTH      = 1;
    localparam int SLOW_DIV      = 4;

    logic                     clock;
    logic                     rst_n;
    logic                     run;
    logic [IN_WIDTH-1:0]      ext_in;
    logic [ACTION_WIDTH-1:0]  action;
    logic                     step;
    logic [COUNTER_COUNT-1:0] ctr_done;

    int tests;
    int failed;

    fsm_sequencer_if #(
        .STATE_COUNT  (STATE_COUNT),
        .COND_WIDTH   (COND_WIDTH),
        .ACTION_WIDTH (ACTION_WIDTH),
        .COUNTER_WIDTH(COUNTER_WIDTH),
        .COUNTER_COUNT(COUNTER_COUNT)
    ) imem_if ();

    fsm_sequencer #(
        .STATE_COUNT  (STATE_COUNT),
        .COND_WIDTH   (COND_WIDTH),
        .ACTION_WIDTH (ACTION_WIDTH),
        .COUNTER_WIDTH(COUNTER_WIDTH),
        .COUNTER_COUNT(COUNTER_COUNT),
        .IN_WIDTH     (IN_WIDTH),
        .SLOW_DIV     (SLOW_DIV)
    ) dut (
        .clock   (clock),
        .rst_n   (rst_n),
        .run     (run),
        .ext_in  (ext_in),
        .imem    (imem_if.slave),
        .action  (action),
        .step    (step),
        .ctr_done(ctr_done)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one active edge and settle before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input logic [2:0] jt, input logic rep, input logic slow,
                            input logic [1:0] cnd, input logic th, input logic el,
                            input logic [15:0] c0, input logic [15:0] c1);
        imem_if.jump_target  = jt;
        imem_if.repeat_state = rep;
        imem_if.slow_mode    = slow;
        imem_if.cond         = cnd;
        imem_if.then_action  = th;
        imem_if.else_action  = el;
        imem_if.const_data   = {c1, c0};
    endtask

    task automatic check_out(input string tag, input logic [2:0] a, input logic act,
                             input logic stp, input logic [1:0] done);
        check({tag, ".addr"},     32'(imem_if.addr), 32'(a));
        check({tag, ".action"},   32'(action),       32'(act));
        check({tag, ".step"},     32'(step),         32'(stp));
        check({tag, ".ctr_done"}, 32'(ctr_done),     32'(done));
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        rst_n  = 1'b0;
        run    = 1'b1;
        ext_in = 1'b0;
        set_word(3'd5, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 16'd3, 16'd0);

        // Reset with run high: everything cleared, counters zero.
        tick();
        tick();
        check_out("reset", 3'd0, 1'b0, 1'b0, 2'b11);

        // First post-reset cycle jumps to target; counters reload (3, 0).
        rst_n = 1'b1;
        tick();
        check_out("post_reset_jump", 3'd5, 1'b1, 1'b1, 2'b10);
        tick();
        check_out("fast_step_again", 3'd5, 1'b1, 1'b1, 2'b10);

        // Idle: parked at 0, counters follow constants.
        run = 1'b0;
        tick();
        check_out("idle", 3'd0, 1'b0, 1'b0, 2'b10);

        // run rises: first cycle steps.
        run = 1'b1;
        tick();
        check_out("run_rise", 3'd5, 1'b1, 1'b1, 2'b10);

        // Stay on ctr0_done with const0=3: 3 stays, jump on the 4th step.
        set_word(3'd2, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 16'd3, 16'd0);
        tick();
        check_out("stay1", 3'd5, 1'b0, 1'b1, 2'b10);
        tick();
        check_out("stay2", 3'd5, 1'b0, 1'b1, 2'b10);
        tick();
        check_out("stay3", 3'd5, 1'b0, 1'b1, 2'b11);
        tick();
        check_out("stay_jump", 3'd2, 1'b1, 1'b1, 2'b10);

        // External input condition jumps to the last state; ctr0 reloads to 3.
        ext_in = 1'b1;
        set_word(3'd7, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 16'd3, 16'd0);
        tick();
        check_out("ext_jump", 3'd7, 1'b1, 1'b1, 2'b10);

        // One stay: ctr0 3 -> 2.
        set_word(3'd1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 16'd3, 16'd0);
        tick();
        check_out("pre_wrap_stay", 3'd7, 1'b0, 1'b1, 2'b10);

        // False condition, no repeat, from state 7: wraps to 0 and reloads
        // ctr0 from a zero constant (a decrement or hold would leave it nonzero).
        ext_in = 1'b0;
        set_word(3'd4, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 16'd0, 16'd0);
        tick();
        check_out("wrap", 3'd0, 1'b1, 1'b1, 2'b11);

        // Slow mode: one step every SLOW_DIV cycles.
        set_word(3'd4, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 16'd3, 16'd0);
        tick();
        check_out("slow_w1", 3'd0, 1'b1, 1'b0, 2'b11);
        tick();
        check_out("slow_w2", 3'd0, 1'b1, 1'b0, 2'b11);
        tick();
        check_out("slow_w3", 3'd0, 1'b1, 1'b0, 2'b11);
        tick();
        check_out("slow_step1", 3'd4, 1'b0, 1'b1, 2'b10);
        set_word(3'd6, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 16'd3, 16'd0);
        tick();
        check_out("slow_w5", 3'd4, 1'b0, 1'b0, 2'b10);
        tick();
        tick();
        check_out("slow_w7", 3'd4, 1'b0, 1'b0, 2'b10);
        tick();
        check_out("slow_step2", 3'd6, 1'b1, 1'b1, 2'b10);

        // Partial count, then a fast cycle must clear the prescaler.
        set_word(3'd1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'd3, 16'd0);
        tick();
        tick();
        check_out("slow_partial", 3'd6, 1'b1, 1'b0, 2'b10);
        set_word(3'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd3, 16'd0);
        tick();
        check_out("fast_between", 3'd1, 1'b0, 1'b1, 2'b10);
        set_word(3'd3, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 16'd3, 16'd0);
        tick();
        tick();
        check_out("slow_restart_w2", 3'd1, 1'b0, 1'b0, 2'b10);
        tick();
        check_out("slow_restart_w3", 3'd1, 1'b0, 1'b0, 2'b10);
        tick();
        check_out("slow_restart_step", 3'd3, 1'b1, 1'b1, 2'b10);

        // Drop run mid-count (ctr0 = 2): idle wins, ctr0 takes const0 = 0.
        set_word(3'd2, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 16'd4, 16'd0);
        tick();
        set_word(3'd0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 16'd4, 16'd0);
        tick();
        tick();
        check_out("count_to_2", 3'd2, 1'b1, 1'b1, 2'b10);
        run = 1'b0;
        set_word(3'd0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 16'd0, 16'd0);
        tick();
        check_out("run_drop", 3'd0, 1'b0, 1'b0, 2'b11);

        // Reset while running clears everything on the next edge.
        run = 1'b1;
        set_word(3'd6, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 16'd7, 16'd9);
        tick();
        check_out("before_reset", 3'd6, 1'b1, 1'b1, 2'b00);
        rst_n = 1'b0;
        tick();
        check_out("reset_while_run", 3'd0, 1'b0, 1'b0, 2'b11);
        rst_n = 1'b1;
        tick();
        check_out("after_reset", 3'd6, 1'b1, 1'b1, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
